// File: rtl/crc_pkg.sv
// Shared CRC definitions for the serial CRC generator/checker pair.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package crc_pkg;

    // One polynomial definition shared by generator and checker.
    localparam int              CRC_WIDTH = 8;
    localparam logic [7:0]      CRC_SEED  = 8'hD8;
    localparam logic [7:0]      CRC_TAPS  = 8'h44;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    // One LFSR update for the default polynomial: feedback enters at the MSB
    // and is XORed into every tapped position on the way down.
    function automatic logic [CRC_WIDTH-1:0] lfsr_step(
        input logic [CRC_WIDTH-1:0] r,
        input logic                 b
    );
        logic                 fb;
        logic [CRC_WIDTH-1:0] n;
        fb = b ^ r[0];
        n  = '0;
        for (int k = 0; k < CRC_WIDTH - 1; k++) begin
            n[k] = r[k+1] ^ (CRC_TAPS[k] & fb);
        end
        n[CRC_WIDTH-1] = fb;
        return n;
    endfunction

endpackage

// File: rtl/crc_lfsr.sv
// CRC LFSR register with load-seed, step (absorb one bit) and shift-out controls.
// Latency: one cycle per operation; load+step seeds and absorbs a bit in the same edge.
// Backpressure: none, the caller decides every cycle what the register does.
module crc_lfsr
    import crc_pkg::*;
#(
    parameter int               WIDTH = CRC_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = CRC_SEED,
    parameter logic [WIDTH-1:0] TAPS  = CRC_TAPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] r
);

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] nxt;
    logic             fb;

    // Next LFSR value; a load in the same cycle makes the step start from SEED.
    always_comb begin
        base = load ? SEED : r;
        fb   = din ^ base[0];
        nxt  = '0;
        for (int k = 0; k < WIDTH - 1; k++) begin
            nxt[k] = base[k+1] ^ (TAPS[k] & fb);
        end
        nxt[WIDTH-1] = fb;
    end

    // Register update: reset > step > shift-out > plain reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= SEED;
        end else if (step) begin
            r <= nxt;
        end else if (shift) begin
            r <= {1'b0, r[WIDTH-1:1]};
        end else if (load) begin
            r <= SEED;
        end
    end

endmodule

// File: rtl/crc_serial_checker.sv
// Bit-serial CRC checker: recomputes the CRC over ACTIVE data bits, compares the trailing WIDTH CRC bits.
// Latency: DONE/CRC_OK/CRC_ERR registered one cycle after the last CRC bit (N+WIDTH edges after first bit).
// Backpressure: none; the serial stream cannot be stalled, ACTIVE during the CRC phase aborts the frame.
module crc_serial_checker
    import crc_pkg::*;
#(
    parameter int               WIDTH = CRC_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = CRC_SEED,
    parameter logic [WIDTH-1:0] TAPS  = CRC_TAPS
) (
    input  logic CLK,
    input  logic RST,
    input  logic Data,
    input  logic ACTIVE,
    output logic BUSY,
    output logic DONE,
    output logic CRC_OK,
    output logic CRC_ERR
);

    localparam int             CW   = $clog2(WIDTH + 1);
    // The first CRC bit is consumed on the DATA->CHECK edge, so CHECK itself
    // handles WIDTH-1 bits with the counter running 0..WIDTH-2.
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 2);

    state_e           state;
    state_e           state_nxt;
    logic [CW-1:0]    cnt;
    logic             mismatch;
    logic [WIDTH-1:0] r;
    logic             lfsr_load;
    logic             lfsr_step_en;
    logic             lfsr_shift;
    logic             bit_err;
    logic             last_bit;

    crc_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED),
        .TAPS  (TAPS)
    ) u_lfsr (
        .clk   (CLK),
        .rst   (RST),
        .load  (lfsr_load),
        .step  (lfsr_step_en),
        .shift (lfsr_shift),
        .din   (Data),
        .r     (r)
    );

    assign bit_err  = Data ^ r[0];
    assign last_bit = (state == ST_CHECK) && !ACTIVE && (cnt == LAST);

    // Next state and LFSR control; any ACTIVE bit outside DATA starts a fresh frame.
    always_comb begin
        state_nxt    = state;
        lfsr_load    = 1'b0;
        lfsr_step_en = 1'b0;
        lfsr_shift   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ACTIVE) begin
                    lfsr_load    = 1'b1;
                    lfsr_step_en = 1'b1;
                    state_nxt    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (ACTIVE) begin
                    lfsr_step_en = 1'b1;
                end else begin
                    lfsr_shift = 1'b1;
                    state_nxt  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (ACTIVE) begin
                    lfsr_load    = 1'b1;
                    lfsr_step_en = 1'b1;
                    state_nxt    = ST_DATA;
                end else begin
                    lfsr_shift = 1'b1;
                    if (cnt == LAST) begin
                        state_nxt = ST_REPORT;
                    end
                end
            end
            default: begin
                if (ACTIVE) begin
                    lfsr_load    = 1'b1;
                    lfsr_step_en = 1'b1;
                    state_nxt    = ST_DATA;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // State, bit counter, sticky mismatch and registered result outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            mismatch <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            CRC_OK   <= 1'b0;
            CRC_ERR  <= 1'b0;
        end else begin
            state <= state_nxt;
            BUSY  <= (state_nxt != ST_IDLE);
            DONE  <= last_bit;
            if (state == ST_DATA && !ACTIVE) begin
                cnt      <= '0;
                mismatch <= bit_err;
            end else if (state == ST_CHECK && !ACTIVE) begin
                cnt      <= cnt + 1'b1;
                mismatch <= mismatch | bit_err;
            end
            if (last_bit) begin
                CRC_OK  <= ~(mismatch | bit_err);
                CRC_ERR <= mismatch | bit_err;
            end
        end
    end

endmodule

// File: tb/tb_crc_serial_checker.sv
// Directed bench for crc_serial_checker: golden, corrupted, back-to-back, abort, reset and length cases.
// Latency: expects DONE visible right after the last CRC bit edge (N+8 edges after the first data bit).
// Backpressure: n/a; stimulus is a fixed-length serial stream.
module tb_crc_serial_checker;

    logic CLK;
    logic RST;
    logic Data;
    logic ACTIVE;
    logic BUSY;
    logic DONE;
    logic CRC_OK;
    logic CRC_ERR;

    int checks = 0;
    int passes = 0;

    crc_serial_checker dut (
        .CLK     (CLK),
        .RST     (RST),
        .Data    (Data),
        .ACTIVE  (ACTIVE),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .CRC_OK  (CRC_OK),
        .CRC_ERR (CRC_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference CRC: seed D8, taps 44 folded into a right-shift-and-XOR-C4 form
    // (C4 = feedback into bit 7 plus tap bits 6 and 2). Hand check: 0x00 -> 0x14, 0xFF -> 0x72.
    function automatic logic [7:0] ref_crc(input logic [63:0] d, input int n);
        logic [7:0] r;
        logic       fb;
        r = 8'hD8;
        for (int i = 0; i < n; i++) begin
            fb = d[i] ^ r[0];
            r  = (r >> 1) ^ (fb ? 8'hC4 : 8'h00);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one bit, let one rising edge pass, settle 1 time unit past it.
    task automatic step(input logic d, input logic a);
        Data   = d;
        ACTIVE = a;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input string tag, input logic [63:0] d, input int n,
                              input logic [7:0] crc, input logic exp_ok, input logic tail);
        int early;
        early = 0;
        for (int i = 0; i < n; i++) begin
            step(d[i], 1'b1);
            if (DONE) early++;
        end
        for (int j = 0; j < 8; j++) begin
            step(crc[j], 1'b0);
            if (j < 7 && DONE) early++;
        end
        chk({tag, "_early_done"}, early, 0);
        chk({tag, "_done"}, DONE, 1);
        chk({tag, "_ok"}, CRC_OK, exp_ok);
        chk({tag, "_err"}, CRC_ERR, !exp_ok);
        chk({tag, "_busy"}, BUSY, 1);
        if (tail) begin
            step(1'b0, 1'b0);
            chk({tag, "_done_drop"}, DONE, 0);
            chk({tag, "_busy_drop"}, BUSY, 0);
            chk({tag, "_ok_held"}, CRC_OK, exp_ok);
        end
    endtask

    task automatic idle_watch(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            step(1'b0, 1'b0);
            if (DONE || BUSY) seen++;
        end
        chk({tag, "_quiet"}, seen, 0);
    endtask

    logic [7:0] gold [10];
    logic [7:0] c;
    int         bad_done;

    initial begin
        gold = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h5A, 8'hC3, 8'h96, 8'h0F, 8'hF0, 8'h81};
        RST    = 1'b1;
        Data   = 1'b0;
        ACTIVE = 1'b0;

        // Reset state
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_ok", CRC_OK, 0);
        chk("rst_err", CRC_ERR, 0);
        RST = 1'b0;
        idle_watch("post_rst", 3);
        chk("post_rst_ok", CRC_OK, 0);
        chk("post_rst_err", CRC_ERR, 0);

        // Hand-computed anchors for the first two golden frames
        send_frame("hand00", 64'h00, 8, 8'h14, 1'b1, 1'b1);
        send_frame("handFF", 64'hFF, 8, 8'h72, 1'b1, 1'b1);

        // Golden frames
        foreach (gold[i]) begin
            send_frame($sformatf("gold%0d", i), 64'(gold[i]), 8, ref_crc(64'(gold[i]), 8), 1'b1, 1'b1);
        end

        // Corruption: CRC bit 0, CRC bit 7, then one data bit
        foreach (gold[i]) begin
            c = ref_crc(64'(gold[i]), 8);
            send_frame($sformatf("crcb0_%0d", i), 64'(gold[i]), 8, c ^ 8'h01, 1'b0, 1'b1);
            send_frame($sformatf("crcb7_%0d", i), 64'(gold[i]), 8, c ^ 8'h80, 1'b0, 1'b1);
            send_frame($sformatf("datab_%0d", i), 64'(gold[i] ^ (8'h01 << (i % 8))), 8, c, 1'b0, 1'b1);
        end

        // Back-to-back: second frame's first bit lands in the REPORT cycle
        send_frame("b2b_5a", 64'h5A, 8, ref_crc(64'h5A, 8), 1'b1, 1'b0);
        send_frame("b2b_c3", 64'hC3, 8, ref_crc(64'hC3, 8), 1'b1, 1'b1);

        // Abort after 3 CRC bits; a failed frame first so held flags are visible
        send_frame("pre_abort", 64'h3C, 8, ref_crc(64'h3C, 8) ^ 8'h10, 1'b0, 1'b1);
        c = ref_crc(64'h96, 8);
        bad_done = 0;
        for (int i = 0; i < 8; i++) begin
            step(gold[6][i], 1'b1);
            if (DONE) bad_done++;
        end
        for (int j = 0; j < 3; j++) begin
            step(c[j], 1'b0);
            if (DONE) bad_done++;
        end
        chk("abort_err_held", CRC_ERR, 1);
        send_frame("after_abort", 64'h3C, 8, ref_crc(64'h3C, 8), 1'b1, 1'b1);
        chk("abort_no_done", bad_done, 0);

        // Reset mid-DATA, with ACTIVE high in the reset cycle
        for (int i = 0; i < 4; i++) step(gold[2][i], 1'b1);
        RST = 1'b1;
        step(1'b1, 1'b1);
        chk("rstd_busy", BUSY, 0);
        chk("rstd_done", DONE, 0);
        chk("rstd_ok", CRC_OK, 0);
        chk("rstd_err", CRC_ERR, 0);
        RST = 1'b0;
        idle_watch("rstd", 10);
        send_frame("rstd_next", 64'hA5, 8, ref_crc(64'hA5, 8), 1'b1, 1'b1);

        // Reset mid-CHECK, preceded by a failed frame so CRC_ERR clears visibly
        send_frame("pre_rstc", 64'h0F, 8, ref_crc(64'h0F, 8) ^ 8'h02, 1'b0, 1'b1);
        c = ref_crc(64'hF0, 8);
        for (int i = 0; i < 8; i++) step(gold[8][i], 1'b1);
        for (int j = 0; j < 3; j++) step(c[j], 1'b0);
        RST = 1'b1;
        step(c[3], 1'b0);
        chk("rstc_busy", BUSY, 0);
        chk("rstc_done", DONE, 0);
        chk("rstc_ok", CRC_OK, 0);
        chk("rstc_err", CRC_ERR, 0);
        RST = 1'b0;
        idle_watch("rstc", 10);
        send_frame("rstc_next", 64'hF0, 8, ref_crc(64'hF0, 8), 1'b1, 1'b1);

        // Frame lengths 1 and 32
        send_frame("len1", 64'h1, 1, ref_crc(64'h1, 1), 1'b1, 1'b1);
        send_frame("len32", 64'hDEADBEEF, 32, ref_crc(64'hDEADBEEF, 32), 1'b1, 1'b1);
        send_frame("len32_bad", 64'hDEADBEEF, 32, ref_crc(64'hDEADBEEF, 32) ^ 8'h40, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
